sc_reg_general: RTL and testbench
=================================

Name: sc_reg_general

Overview:
- Parametrised general-purpose datapath register that generalises the fixed-value register.
- Holds a DATAWIDTH_BUS-bit value with a programmable reset/clear value.
- Each cycle, a 3-bit mode input selects one operation: hold, parallel load, increment, decrement, shift left, shift right, or clear.
- Exports a registered carry/shift-out flag and a zero flag for the uDATAPATH control unit; also serves as program counter, loop counter or shift register.

Parameters:
- DATAWIDTH_BUS, 32, register and data bus width (>=2)
- DATA_REGGENERAL_INIT, 0, value loaded on reset and by CLEAR (DATAWIDTH_BUS bits)
- INC_STEP, 1, step added by INC and subtracted by DEC (must fit in DATAWIDTH_BUS bits)

Ports:
- SC_RegGENERAL_CLOCK_50  in  1  system clock; all state updates on rising edge
- SC_RegGENERAL_RESET_InHigh  in  1  synchronous, active-high reset
- SC_RegGENERAL_mode_InBus  in  3  operation select, sampled every rising edge
- SC_RegGENERAL_data_InBus  in  DATAWIDTH_BUS  parallel load data
- SC_RegGENERAL_serial_In  in  1  bit shifted into vacated position on SHL/SHR
- SC_RegGENERAL_data_OutBus  out  DATAWIDTH_BUS  current register contents
- SC_RegGENERAL_carry_Out  out  1  registered carry/borrow/shift-out flag
- SC_RegGENERAL_zero_Out  out  1  high when register == 0 (combinational from register)

Behaviour:
- One clock; reset is synchronous and active-high. Reset is sampled only on a rising edge and takes priority over every mode: register <= DATA_REGGENERAL_INIT, carry <= 0.
- After reset: data_OutBus = DATA_REGGENERAL_INIT, carry_Out = 0, zero_Out = (INIT == 0).
- Modes, each acting at a rising edge with reset low:
  - 000 HOLD: register and carry unchanged.
  - 001 LOAD: register <= data_InBus; carry <= 0.
  - 010 INC: {carry, register} <= register + INC_STEP, computed at DATAWIDTH_BUS+1 bits. Wraps modulo 2^W; carry = 1 on wrap.
  - 011 DEC: register <= register - INC_STEP modulo 2^W; carry <= 1 iff register < INC_STEP (borrow).
  - 100 SHL: register <= {register[W-2:0], serial_In}; carry <= old register[W-1].
  - 101 SHR (logical): register <= {serial_In, register[W-1:1]}; carry <= old register[0].
  - 110 CLEAR: register <= DATA_REGGENERAL_INIT; carry <= 0.
  - 111 reserved: behaves exactly as HOLD; no state change.
- Latency: one cycle. The result of the operation sampled at edge N is visible on data_OutBus and carry_Out immediately after edge N. zero_Out follows data_OutBus combinationally in the same cycle.
- Outputs are driven directly from state; no combinational path from any input to any output.
- Boundary conditions:
  - INC of all-ones with INC_STEP = 1 -> 0, carry = 1, zero = 1.
  - DEC of 0 -> all-ones, carry = 1, zero = 0.
  - Back-to-back ops: each operation uses the value left by the previous edge. No bypass, no stall.
  - Reset asserted mid-sequence (e.g., during a shift train): the register takes INIT at that edge and the in-flight mode is discarded. Normal operation resumes the cycle after reset deasserts.
  - Mode or data changing between edges has no effect; only values at the rising edge matter.
- No X propagation: every mode encoding is defined. The register is never left unassigned.

Decomposition:
- Shared package sc_reg_pkg holds:
  - 3-bit mode localparams MODE_HOLD, MODE_LOAD, MODE_INC, MODE_DEC, MODE_SHL, MODE_SHR, MODE_CLEAR, MODE_RSVD.
  - The mode width constant (3).
- The control unit and other datapath registers import the same package.
- One natural sub-module: sc_reg_general_nextstate. It is purely combinational: it takes the register, mode, data_InBus and serial_In, and produces next value and next carry.
- The top level holds the synchronous-reset state register, carry flop and zero compare.

Test Plan:
All scenarios use W = 8, INIT = 8'hA5, INC_STEP = 1.
1. Reset held 2 cycles, then mode = HOLD for 3 cycles -> data_OutBus = 8'hA5 throughout, carry = 0, zero = 0. Then CLEAR -> 8'hA5.
2. LOAD 8'hFE, then INC, INC -> outputs 8'hFE/c0, 8'hFF/c0, 8'h00/c1/zero = 1. Then DEC -> 8'hFF, carry = 1, zero = 0.
3. LOAD 8'h81, then SHL with serial_In = 0 -> 8'h02, carry = 1. Then SHR with serial_In = 1 -> 8'h81, carry = 0.
4. LOAD 8'h3C, then mode 111 for 4 cycles, varying data_InBus and serial_In -> stays 8'h3C, carry unchanged.
5. LOAD 8'h01, then SHL train; assert reset on the 3rd SHL edge -> 8'h02, 8'h04, then 8'hA5 with carry = 0. Next SHL (serial_In = 1) -> 8'h4B, carry = 1.
6. Reset and LOAD asserted at the same edge with data 8'h00 -> 8'hA5, zero = 0 (reset wins). Next edge LOAD 8'h00 -> zero = 1.

Source files
------------

// File: rtl/sc_reg_pkg.sv
// -----------------------------------------------------------------------------
// sc_reg_pkg
// Shared definitions for the uDATAPATH register family: the width of the
// operation-select field and the encodings of every register operation.
// Imported by the general register, its next-state logic and the control unit.
// -----------------------------------------------------------------------------
package sc_reg_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD  = 3'b000;
    localparam mode_t MODE_LOAD  = 3'b001;
    localparam mode_t MODE_INC   = 3'b010;
    localparam mode_t MODE_DEC   = 3'b011;
    localparam mode_t MODE_SHL   = 3'b100;
    localparam mode_t MODE_SHR   = 3'b101;
    localparam mode_t MODE_CLEAR = 3'b110;
    localparam mode_t MODE_RSVD  = 3'b111;

endpackage

// File: rtl/sc_reg_general_if.sv
// -----------------------------------------------------------------------------
// sc_reg_general_if
// Bus bundle between a controller and one general-purpose datapath register.
//   SC_RegGENERAL_mode_InBus   operation select (controller -> register)
//   SC_RegGENERAL_data_InBus   parallel load data (controller -> register)
//   SC_RegGENERAL_serial_In    shift-in bit (controller -> register)
//   SC_RegGENERAL_data_OutBus  register contents (register -> controller)
//   SC_RegGENERAL_carry_Out    registered carry/borrow/shift-out flag
//   SC_RegGENERAL_zero_Out     register == 0
// Modports: master = controller side, slave = register side.
// -----------------------------------------------------------------------------
interface sc_reg_general_if #(
    parameter int DATAWIDTH_BUS = 32
);
    import sc_reg_pkg::*;

    mode_t                    SC_RegGENERAL_mode_InBus;
    logic [DATAWIDTH_BUS-1:0] SC_RegGENERAL_data_InBus;
    logic                     SC_RegGENERAL_serial_In;
    logic [DATAWIDTH_BUS-1:0] SC_RegGENERAL_data_OutBus;
    logic                     SC_RegGENERAL_carry_Out;
    logic                     SC_RegGENERAL_zero_Out;

    modport master (
        output SC_RegGENERAL_mode_InBus,
        output SC_RegGENERAL_data_InBus,
        output SC_RegGENERAL_serial_In,
        input  SC_RegGENERAL_data_OutBus,
        input  SC_RegGENERAL_carry_Out,
        input  SC_RegGENERAL_zero_Out
    );

    modport slave (
        input  SC_RegGENERAL_mode_InBus,
        input  SC_RegGENERAL_data_InBus,
        input  SC_RegGENERAL_serial_In,
        output SC_RegGENERAL_data_OutBus,
        output SC_RegGENERAL_carry_Out,
        output SC_RegGENERAL_zero_Out
    );

endinterface

// File: rtl/sc_reg_general_nextstate.sv
// -----------------------------------------------------------------------------
// sc_reg_general_nextstate
// Purely combinational next-value / next-carry logic for sc_reg_general.
//   reg_q      in   current register value
//   carry_q    in   current carry flag (kept on HOLD / reserved)
//   mode       in   operation select
//   data_in    in   parallel load data
//   serial_in  in   bit shifted into the vacated position on SHL/SHR
//   reg_next   out  value the register takes at the next edge
//   carry_next out  value the carry flag takes at the next edge
// -----------------------------------------------------------------------------
module sc_reg_general_nextstate
    import sc_reg_pkg::*;
#(
    parameter int                       DATAWIDTH_BUS        = 32,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGGENERAL_INIT = '0,
    parameter int                       INC_STEP             = 1
) (
    input  logic [DATAWIDTH_BUS-1:0] reg_q,
    input  logic                     carry_q,
    input  mode_t                    mode,
    input  logic [DATAWIDTH_BUS-1:0] data_in,
    input  logic                     serial_in,
    output logic [DATAWIDTH_BUS-1:0] reg_next,
    output logic                     carry_next
);

    localparam logic [DATAWIDTH_BUS-1:0] STEP = DATAWIDTH_BUS'(INC_STEP);

    // One extra bit so the wrap of INC lands in the MSB as the carry.
    logic [DATAWIDTH_BUS:0]   inc_wide;
    logic [DATAWIDTH_BUS-1:0] dec_val;
    logic                     dec_borrow;

    assign inc_wide   = {1'b0, reg_q} + {1'b0, STEP};
    assign dec_val    = reg_q - STEP;
    assign dec_borrow = (reg_q < STEP);

    always_comb begin
        // HOLD and the reserved encoding both fall through to these defaults.
        reg_next   = reg_q;
        carry_next = carry_q;
        case (mode)
            MODE_LOAD: begin
                reg_next   = data_in;
                carry_next = 1'b0;
            end
            MODE_INC: begin
                reg_next   = inc_wide[DATAWIDTH_BUS-1:0];
                carry_next = inc_wide[DATAWIDTH_BUS];
            end
            MODE_DEC: begin
                reg_next   = dec_val;
                carry_next = dec_borrow;
            end
            MODE_SHL: begin
                reg_next   = {reg_q[DATAWIDTH_BUS-2:0], serial_in};
                carry_next = reg_q[DATAWIDTH_BUS-1];
            end
            MODE_SHR: begin
                reg_next   = {serial_in, reg_q[DATAWIDTH_BUS-1:1]};
                carry_next = reg_q[0];
            end
            MODE_CLEAR: begin
                reg_next   = DATA_REGGENERAL_INIT;
                carry_next = 1'b0;
            end
            default: begin
                reg_next   = reg_q;
                carry_next = carry_q;
            end
        endcase
    end

endmodule

// File: rtl/sc_reg_general.sv
// -----------------------------------------------------------------------------
// sc_reg_general
// General-purpose datapath register: hold / load / increment / decrement /
// shift left / shift right / clear, selected per cycle by a 3-bit mode.
// Usable as program counter, loop counter or shift register.
//   SC_RegGENERAL_CLOCK_50      in   clock, all updates on rising edge
//   SC_RegGENERAL_RESET_InHigh  in   synchronous active-high reset
//   bus (slave)                      mode, load data, serial-in in;
//                                    data, carry and zero flags out
// Outputs come straight from the flops (zero is a compare on the register),
// so there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module sc_reg_general
    import sc_reg_pkg::*;
#(
    parameter int                       DATAWIDTH_BUS        = 32,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGGENERAL_INIT = '0,
    parameter int                       INC_STEP             = 1
) (
    input  logic                SC_RegGENERAL_CLOCK_50,
    input  logic                SC_RegGENERAL_RESET_InHigh,
    sc_reg_general_if.slave     bus
);

    logic [DATAWIDTH_BUS-1:0] reg_q;
    logic [DATAWIDTH_BUS-1:0] reg_d;
    logic                     carry_q;
    logic                     carry_d;

    sc_reg_general_nextstate #(
        .DATAWIDTH_BUS        (DATAWIDTH_BUS),
        .DATA_REGGENERAL_INIT (DATA_REGGENERAL_INIT),
        .INC_STEP             (INC_STEP)
    ) u_nextstate (
        .reg_q      (reg_q),
        .carry_q    (carry_q),
        .mode       (bus.SC_RegGENERAL_mode_InBus),
        .data_in    (bus.SC_RegGENERAL_data_InBus),
        .serial_in  (bus.SC_RegGENERAL_serial_In),
        .reg_next   (reg_d),
        .carry_next (carry_d)
    );

    // Reset overrides whatever operation is presented at the same edge.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            reg_q   <= DATA_REGGENERAL_INIT;
            carry_q <= 1'b0;
        end else begin
            reg_q   <= reg_d;
            carry_q <= carry_d;
        end
    end

    assign bus.SC_RegGENERAL_data_OutBus = reg_q;
    assign bus.SC_RegGENERAL_carry_Out   = carry_q;
    assign bus.SC_RegGENERAL_zero_Out    = (reg_q == '0);

endmodule

// File: tb/tb_sc_reg_general.sv
// -----------------------------------------------------------------------------
// tb_sc_reg_general
// Directed bench for sc_reg_general with W = 8, INIT = 8'hA5, INC_STEP = 1.
// Inputs change on the falling edge; outputs are checked 1 ns after each
// rising edge against hand-computed values. One line per transaction.
// -----------------------------------------------------------------------------
module tb_sc_reg_general;
    import sc_reg_pkg::*;

    localparam int         W    = 8;
    localparam logic [7:0] INIT = 8'hA5;

    logic clk;
    logic srst;
    int   errors = 0;
    int   checks = 0;

    sc_reg_general_if #(.DATAWIDTH_BUS(W)) bus ();

    sc_reg_general #(
        .DATAWIDTH_BUS        (W),
        .DATA_REGGENERAL_INIT (INIT),
        .INC_STEP             (1)
    ) dut (
        .SC_RegGENERAL_CLOCK_50     (clk),
        .SC_RegGENERAL_RESET_InHigh (srst),
        .bus                        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation, clock it, then check all three outputs.
    task automatic step(input string tag, input logic rst, input mode_t mode,
                        input logic [7:0] din, input logic sin,
                        input logic [7:0] exp_d, input logic exp_c, input logic exp_z);
        @(negedge clk);
        srst                         = rst;
        bus.SC_RegGENERAL_mode_InBus = mode;
        bus.SC_RegGENERAL_data_InBus = din;
        bus.SC_RegGENERAL_serial_In  = sin;
        @(posedge clk);
        #1;
        $display("%-10s rst=%0b mode=%03b din=%02h sin=%0b -> data=%02h carry=%0b zero=%0b",
                 tag, rst, mode, din, sin, bus.SC_RegGENERAL_data_OutBus,
                 bus.SC_RegGENERAL_carry_Out, bus.SC_RegGENERAL_zero_Out);
        checks++;
        assert (bus.SC_RegGENERAL_data_OutBus === exp_d) else begin
            errors++;
            $error("FAIL %s data: got %02h expected %02h", tag, bus.SC_RegGENERAL_data_OutBus, exp_d);
        end
        checks++;
        assert (bus.SC_RegGENERAL_carry_Out === exp_c) else begin
            errors++;
            $error("FAIL %s carry: got %0b expected %0b", tag, bus.SC_RegGENERAL_carry_Out, exp_c);
        end
        checks++;
        assert (bus.SC_RegGENERAL_zero_Out === exp_z) else begin
            errors++;
            $error("FAIL %s zero: got %0b expected %0b", tag, bus.SC_RegGENERAL_zero_Out, exp_z);
        end
    endtask

    initial begin
        srst                         = 1'b1;
        bus.SC_RegGENERAL_mode_InBus = MODE_HOLD;
        bus.SC_RegGENERAL_data_InBus = 8'h00;
        bus.SC_RegGENERAL_serial_In  = 1'b0;

        // 1. reset, hold, clear
        step("rst1",    1'b1, MODE_HOLD,  8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
        step("rst2",    1'b1, MODE_HOLD,  8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
        step("hold1",   1'b0, MODE_HOLD,  8'h12, 1'b1, 8'hA5, 1'b0, 1'b0);
        step("hold2",   1'b0, MODE_HOLD,  8'h34, 1'b0, 8'hA5, 1'b0, 1'b0);
        step("hold3",   1'b0, MODE_HOLD,  8'h56, 1'b1, 8'hA5, 1'b0, 1'b0);
        step("clear",   1'b0, MODE_CLEAR, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);

        // 2. increment across the wrap, decrement back
        step("loadFE",  1'b0, MODE_LOAD,  8'hFE, 1'b0, 8'hFE, 1'b0, 1'b0);
        step("inc1",    1'b0, MODE_INC,   8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        step("inc2",    1'b0, MODE_INC,   8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        step("dec0",    1'b0, MODE_DEC,   8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
        step("rsvdC1",  1'b0, MODE_RSVD,  8'h77, 1'b1, 8'hFF, 1'b1, 1'b0);
        step("holdC1",  1'b0, MODE_HOLD,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
        step("dec1",    1'b0, MODE_DEC,   8'h00, 1'b0, 8'hFE, 1'b0, 1'b0);

        // 3. shift out on both ends
        step("load81",  1'b0, MODE_LOAD,  8'h81, 1'b0, 8'h81, 1'b0, 1'b0);
        step("shl",     1'b0, MODE_SHL,   8'h00, 1'b0, 8'h02, 1'b1, 1'b0);
        step("shr",     1'b0, MODE_SHR,   8'h00, 1'b1, 8'h81, 1'b0, 1'b0);

        // 4. reserved mode is a hold regardless of data/serial
        step("load3C",  1'b0, MODE_LOAD,  8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0);
        step("rsvd1",   1'b0, MODE_RSVD,  8'hFF, 1'b1, 8'h3C, 1'b0, 1'b0);
        step("rsvd2",   1'b0, MODE_RSVD,  8'h00, 1'b0, 8'h3C, 1'b0, 1'b0);
        step("rsvd3",   1'b0, MODE_RSVD,  8'hAA, 1'b1, 8'h3C, 1'b0, 1'b0);
        step("rsvd4",   1'b0, MODE_RSVD,  8'h55, 1'b0, 8'h3C, 1'b0, 1'b0);

        // 5. reset in the middle of a shift train
        step("load01",  1'b0, MODE_LOAD,  8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
        step("shlA",    1'b0, MODE_SHL,   8'h00, 1'b0, 8'h02, 1'b0, 1'b0);
        step("shlB",    1'b0, MODE_SHL,   8'h00, 1'b0, 8'h04, 1'b0, 1'b0);
        step("shlRst",  1'b1, MODE_SHL,   8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
        step("shlC",    1'b0, MODE_SHL,   8'h00, 1'b1, 8'h4B, 1'b1, 1'b0);

        // 6. reset beats a simultaneous load
        step("rstLoad", 1'b1, MODE_LOAD,  8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
        step("load00",  1'b0, MODE_LOAD,  8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
